// File: rtl/display_pkg.sv
// Shared constants and state encoding for the HUB75 scan path.
//   PANEL_COLS / ROW_PAIRS : panel geometry (64 columns, 32 row pairs)
//   COL_W / ROW_W          : pixel-memory address widths
//   scan_state_t           : shift FSM states
package display_pkg;

  localparam int unsigned PANEL_COLS = 64;
  localparam int unsigned ROW_PAIRS  = 32;
  localparam int unsigned COL_W      = 6;
  localparam int unsigned ROW_W      = 5;

  typedef enum logic [2:0] {
    S_ADDR,
    S_DATA,
    S_CLK,
    S_WAIT,
    S_BLANK,
    S_LATCH
  } scan_state_t;

endpackage

// File: rtl/hub75_scan_driver.sv
// HUB75 scan controller for a 64x64 panel fed from the dual-SPRAM pixel memory.
// Reads one row pair column by column, shifts it into the panel, then blanks,
// latches and shows it while the next row pair is shifted.
// Ports:
//   clk, rst_n              : system clock, async active-low reset
//   mem_write_en            : pixel-memory write in progress (port busy)
//   R1..B2                  : pixel-memory read data, valid one cycle after address
//   col_addr, row_addr      : pixel-memory read address
//   panel_r1..panel_b2      : panel serial data
//   panel_clk, panel_lat    : panel shift clock and latch pulse
//   panel_oe_n, panel_addr  : output enable (active low), displayed row pair
//   frame_done              : one-cycle pulse when row pair 31 is latched
module hub75_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned ON_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_write_en,
  input  logic             R1,
  input  logic             G1,
  input  logic             B1,
  input  logic             R2,
  input  logic             G2,
  input  logic             B2,
  output logic [COL_W-1:0] col_addr,
  output logic [ROW_W-1:0] row_addr,
  output logic             panel_r1,
  output logic             panel_g1,
  output logic             panel_b1,
  output logic             panel_r2,
  output logic             panel_g2,
  output logic             panel_b2,
  output logic             panel_clk,
  output logic             panel_lat,
  output logic             panel_oe_n,
  output logic [ROW_W-1:0] panel_addr,
  output logic             frame_done
);

  localparam int unsigned TIMER_W = $clog2(ON_CYCLES + 1);

  scan_state_t        state;
  logic [TIMER_W-1:0] on_cnt;
  logic               last_col;
  logic               on_ending;

  assign last_col  = (col_addr == COL_W'(PANEL_COLS - 1));
  // Blank cycle may follow as soon as the remaining on-time is at most one cycle,
  // so the blank output lines up with the first cycle panel_oe_n is high.
  assign on_ending = (on_cnt <= TIMER_W'(1));

  // Shift FSM, on-timer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_ADDR;
      on_cnt     <= '0;
      col_addr   <= '0;
      row_addr   <= '0;
      panel_r1   <= 1'b0;
      panel_g1   <= 1'b0;
      panel_b1   <= 1'b0;
      panel_r2   <= 1'b0;
      panel_g2   <= 1'b0;
      panel_b2   <= 1'b0;
      panel_clk  <= 1'b0;
      panel_lat  <= 1'b0;
      panel_oe_n <= 1'b1;
      panel_addr <= '0;
      frame_done <= 1'b0;
    end else begin
      panel_lat  <= 1'b0;
      frame_done <= 1'b0;

      // On-timer: enable is low while the count is non-zero; writes never touch it.
      panel_oe_n <= (on_cnt == '0);
      if (state == S_LATCH) begin
        on_cnt <= TIMER_W'(ON_CYCLES);
      end else if (on_cnt != '0) begin
        on_cnt <= on_cnt - TIMER_W'(1);
      end

      case (state)
        S_ADDR: begin
          panel_clk <= 1'b0;
          // Memory port is carrying a write: hold the column and retry.
          if (!mem_write_en) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          {panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2} <= {R1, G1, B1, R2, G2, B2};
          state <= S_CLK;
        end
        S_CLK: begin
          panel_clk <= 1'b1;
          if (last_col) begin
            // Skip the wait entirely when the on-time has already run out.
            state <= on_ending ? S_BLANK : S_WAIT;
          end else begin
            col_addr <= col_addr + COL_W'(1);
            state    <= S_ADDR;
          end
        end
        S_WAIT: begin
          panel_clk <= 1'b0;
          if (on_ending) begin
            state <= S_BLANK;
          end
        end
        S_BLANK: begin
          panel_clk <= 1'b0;
          state     <= S_LATCH;
        end
        S_LATCH: begin
          panel_clk  <= 1'b0;
          panel_lat  <= 1'b1;
          panel_addr <= row_addr;
          frame_done <= (row_addr == ROW_W'(ROW_PAIRS - 1));
          row_addr   <= row_addr + ROW_W'(1);
          col_addr   <= '0;
          state      <= S_ADDR;
        end
        default: state <= S_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: two instances (ON_CYCLES 256 and 8) read a
// behavioural 64x64 framebuffer through a 1-cycle-latency memory model.
module tb_hub75_scan_driver;

  typedef struct { int cyc; logic [5:0] d; } rise_t;
  typedef struct { int cyc; logic [4:0] a; logic fd; } lat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       mem_we;
  logic [5:0] rd_a, rd_b;
  logic [5:0] col_a, col_b;
  logic [4:0] row_a, row_b;
  logic [5:0] pd_a, pd_b;
  logic       pclk_a, pclk_b, lat_a, lat_b, oe_a, oe_b, fd_a, fd_b;
  logic [4:0] paddr_a, paddr_b;

  // Framebuffer, pix[y][x] = {R,G,B}; row pair r covers y = r and y = r + 32.
  logic [2:0] pix [64][64];

  hub75_scan_driver #(.ON_CYCLES(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .mem_write_en(mem_we),
    .R1(rd_a[5]), .G1(rd_a[4]), .B1(rd_a[3]), .R2(rd_a[2]), .G2(rd_a[1]), .B2(rd_a[0]),
    .col_addr(col_a), .row_addr(row_a),
    .panel_r1(pd_a[5]), .panel_g1(pd_a[4]), .panel_b1(pd_a[3]),
    .panel_r2(pd_a[2]), .panel_g2(pd_a[1]), .panel_b2(pd_a[0]),
    .panel_clk(pclk_a), .panel_lat(lat_a), .panel_oe_n(oe_a),
    .panel_addr(paddr_a), .frame_done(fd_a)
  );

  hub75_scan_driver #(.ON_CYCLES(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem_write_en(mem_we),
    .R1(rd_b[5]), .G1(rd_b[4]), .B1(rd_b[3]), .R2(rd_b[2]), .G2(rd_b[1]), .B2(rd_b[0]),
    .col_addr(col_b), .row_addr(row_b),
    .panel_r1(pd_b[5]), .panel_g1(pd_b[4]), .panel_b1(pd_b[3]),
    .panel_r2(pd_b[2]), .panel_g2(pd_b[1]), .panel_b2(pd_b[0]),
    .panel_clk(pclk_b), .panel_lat(lat_b), .panel_oe_n(oe_b),
    .panel_addr(paddr_b), .frame_done(fd_b)
  );

  // Synchronous-read memory; while a write owns the port the read data is junk.
  always @(posedge clk) begin
    if (mem_we) begin
      rd_a <= ~{pix[{1'b0, row_a}][col_a], pix[{1'b1, row_a}][col_a]};
      rd_b <= ~{pix[{1'b0, row_b}][col_b], pix[{1'b1, row_b}][col_b]};
    end else begin
      rd_a <= {pix[{1'b0, row_a}][col_a], pix[{1'b1, row_a}][col_a]};
      rd_b <= {pix[{1'b0, row_b}][col_b], pix[{1'b1, row_b}][col_b]};
    end
  end

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  logic  prev_pclk = 1'b0;
  int    oe_run = 0, oeb_run = 0, fd_count = 0;
  rise_t rise_q[$];
  lat_t  lat_q[$];
  int    latb_q[$];
  int    oe_q[$];
  int    oeb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the edge; records panel events.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (pclk_a && !prev_pclk) rise_q.push_back('{cyc, pd_a});
    prev_pclk = pclk_a;
    if (lat_a) lat_q.push_back('{cyc, paddr_a, fd_a});
    if (fd_a) fd_count++;
    if (lat_b) latb_q.push_back(cyc);
    if (!oe_a) oe_run++;
    else if (oe_run != 0) begin oe_q.push_back(oe_run); oe_run = 0; end
    if (!oe_b) oeb_run++;
    else if (oeb_run != 0) begin oeb_q.push_back(oeb_run); oeb_run = 0; end
  endtask

  task automatic clear_q();
    rise_q.delete(); lat_q.delete(); latb_q.delete(); oe_q.delete(); oeb_q.delete();
    oe_run = 0; oeb_run = 0;
  endtask

  task automatic wait_lat(input int bound);
    int n = 0;
    while (lat_q.size() == 0 && n < bound) begin step(); n++; end
    if (lat_q.size() == 0) begin
      chk("lat_timeout", 32'(lat_q.size()), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  endtask

  // Checks one latched row pair against the framebuffer (or the x+y pattern).
  task automatic check_row(input int r, input bit pattern, output int lat_cyc, output int last_rise);
    lat_t       l;
    logic [5:0] e;
    int         n;
    l = lat_q.pop_front();
    chk("lat_addr", 32'(l.a), 32'(r));
    chk("frame_done_at_lat", 32'(l.fd), 32'(r == 31));
    n = rise_q.size();
    chk("rise_count", 32'(n), 32'd64);
    for (int c = 0; c < 64 && c < n; c++) begin
      if (pattern) e = {3'(c % 8), 3'((c + 32) % 8)};
      else         e = {pix[6'(r)][6'(c)], pix[6'(r + 32)][6'(c)]};
      chk($sformatf("row%0d_col%0d_data", r, c), 32'(rise_q[c].d), 32'(e));
    end
    lat_cyc   = l.cyc;
    last_rise = (n > 0) ? rise_q[n-1].cyc : -1;
    rise_q.delete();
  endtask

  initial begin
    int k, lc, lr, l0, l1, prev, fstart;
    rst_n  = 1'b0;
    mem_we = 1'b0;
    // Pattern (x+y) mod 8 on the row pair 0 lines, random everywhere else.
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        pix[6'(y)][6'(x)] = (y == 0 || y == 32) ? 3'((x + y) % 8) : 3'($urandom);

    // Reset values.
    repeat (5) step();
    chk("rst_col", 32'(col_a), 0);
    chk("rst_row", 32'(row_a), 0);
    chk("rst_data", 32'(pd_a), 0);
    chk("rst_pclk", 32'(pclk_a), 0);
    chk("rst_lat", 32'(lat_a), 0);
    chk("rst_oe_n", 32'(oe_a), 1);
    chk("rst_paddr", 32'(paddr_a), 0);
    chk("rst_fd", 32'(fd_a), 0);
    chk("rst_b_oe_n", 32'(oe_b), 1);
    chk("rst_b_data", 32'(pd_b), 0);
    chk("rst_b_pclk", 32'(pclk_b), 0);
    chk("rst_b_lat", 32'(lat_b), 0);
    chk("rst_b_paddr", 32'(paddr_b), 0);
    chk("rst_b_fd", 32'(fd_b), 0);

    // First panel_clk rise after release.
    clear_q();
    rst_n = 1'b1;
    k = 0;
    while (!pclk_a && k < 10) begin step(); k++; end
    chk("first_rise_delay", 32'(k), 32'd3);

    // Row 0 with the fixed pattern, display blanked throughout.
    wait_lat(400);
    check_row(0, 1'b1, l0, lr);
    chk("oe_blank_first_row", 32'(oe_q.size()), 0);

    // Row 1 with a 5-cycle write stall at column 10.
    k = 0;
    while (col_a != 6'd10 && k < 100) begin step(); k++; end
    chk("reach_col10", 32'(col_a), 32'd10);
    mem_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pix[6'(17 + 32 * ($urandom % 2))][6'($urandom % 64)] = 3'($urandom);
      step();
      chk("stall_col_held", 32'(col_a), 32'd10);
    end
    mem_we = 1'b0;
    wait_lat(400);
    check_row(1, 1'b0, l1, lr);
    chk("stall_shift_len", 32'(lr - l0), 32'd197);
    chk("lat_spacing_stall", 32'(l1 - l0), 32'd258);
    chk("oe_runs_row0", 32'(oe_q.size()), 32'd1);
    if (oe_q.size() > 0) chk("oe_low_len", 32'(oe_q.pop_front()), 32'd256);

    // Rest of the frame and the wrap back to row 0.
    latb_q.delete(); oeb_q.delete();
    fd_count = 0;
    prev = l1;
    fstart = l0;
    for (int n = 2; n <= 32; n++) begin
      wait_lat(600);
      check_row(n % 32, (n % 32) == 0, lc, lr);
      chk("lat_spacing", 32'(lc - prev), 32'd258);
      if (oe_q.size() > 0) chk("oe_low_len", 32'(oe_q.pop_front()), 32'd256);
      else chk("oe_run_seen", 32'(oe_q.size()), 32'd1);
      prev = lc;
    end
    chk("frame_done_count", 32'(fd_count), 32'd1);
    chk("frame_len", 32'(prev - fstart), 32'd8256);

    // Short on-time instance: spacing set by the shift time alone.
    chk("b_lats_seen", 32'(latb_q.size() >= 11), 32'd1);
    for (int i = 1; i < 11 && i < latb_q.size(); i++)
      chk("b_lat_spacing", 32'(latb_q[i] - latb_q[i-1]), 32'd194);
    for (int i = 0; i < 5 && i < oeb_q.size(); i++)
      chk("b_oe_low_len", 32'(oeb_q[i]), 32'd8);

    // Reset in the middle of row 7, column 40.
    k = 0;
    while (!(row_a == 5'd7 && col_a == 6'd40) && k < 3000) begin step(); k++; end
    chk("reach_row7_col40", 32'({row_a, col_a}), 32'({5'd7, 6'd40}));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_col", 32'(col_a), 0);
    chk("mid_rst_row", 32'(row_a), 0);
    chk("mid_rst_data", 32'(pd_a), 0);
    chk("mid_rst_pclk", 32'(pclk_a), 0);
    chk("mid_rst_lat", 32'(lat_a), 0);
    chk("mid_rst_oe_n", 32'(oe_a), 1);
    chk("mid_rst_paddr", 32'(paddr_a), 0);
    chk("mid_rst_fd", 32'(fd_a), 0);
    repeat (3) step();
    clear_q();
    rst_n = 1'b1;
    wait_lat(400);
    check_row(0, 1'b1, lc, lr);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
